// File: rtl/ksa_pkg.sv
// Shared definitions for the pipelined Kogge-Stone adder.
//   clog2          : constant ceiling-log2 used to size the prefix tree
//   KSA_MAX_W      : widest supported operand
//   KSA_MAX_LEVELS : prefix depth at the widest operand
//   pg_t           : generate/propagate vector pair, sized for the widest operand
package ksa_pkg;

  localparam int unsigned KSA_MAX_W = 64;

  // Smallest r with 2**r >= value.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

  localparam int unsigned KSA_MAX_LEVELS = clog2(KSA_MAX_W);

  typedef struct packed {
    logic [KSA_MAX_W-1:0] g;
    logic [KSA_MAX_W-1:0] p;
  } pg_t;

endpackage

// File: rtl/ksa_prefix_level.sv
// One Kogge-Stone prefix level: every bit j >= DIST merges its (G,P) group
// with the group ending DIST bits lower.
//   clk, rst_n     : clock, asynchronous active-low reset
//   flush          : clears the travelling valid bit (registered variant)
//   prev_valid/g/p : upstream valid tag and group generate/propagate
//   prev_side      : payload carried unchanged alongside (bit propagates, carry-in)
//   next_*         : downstream copies, registered when REG=1, combinational when REG=0
module ksa_prefix_level #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIST   = 1,
  parameter int unsigned SIDE_W = 9,
  parameter bit          REG    = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              prev_valid,
  input  logic [WIDTH-1:0]  prev_g,
  input  logic [WIDTH-1:0]  prev_p,
  input  logic [SIDE_W-1:0] prev_side,
  output logic              next_valid,
  output logic [WIDTH-1:0]  next_g,
  output logic [WIDTH-1:0]  next_p,
  output logic [SIDE_W-1:0] next_side
);

  logic [WIDTH-1:0] g_c;
  logic [WIDTH-1:0] p_c;

  // Group merge; bits below DIST already span down to bit 0 and pass through.
  always_comb begin
    g_c = prev_g;
    p_c = prev_p;
    for (int unsigned j = DIST; j < WIDTH; j++) begin
      g_c[j] = prev_g[j] | (prev_p[j] & prev_g[j-DIST]);
      p_c[j] = prev_p[j] & prev_p[j-DIST];
    end
  end

  if (REG) begin : g_reg
    // Pipeline register for this level; data may update on invalid slots.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        next_valid <= 1'b0;
        next_g     <= '0;
        next_p     <= '0;
        next_side  <= '0;
      end else begin
        next_valid <= prev_valid & ~flush;
        next_g     <= g_c;
        next_p     <= p_c;
        next_side  <= prev_side;
      end
    end
  end else begin : g_comb
    // Combinational level; flush is applied further down the pipe.
    logic unused_ok;
    assign unused_ok  = ^{clk, rst_n, flush};
    assign next_valid = prev_valid;
    assign next_g     = g_c;
    assign next_p     = p_c;
    assign next_side  = prev_side;
  end

endmodule

// File: rtl/ksa_pipe_adder.sv
// Parametrised pipelined Kogge-Stone adder with valid tagging, flush,
// result counter and signed-overflow flag. One result per clock, in order.
// Optional feature macro: KSA_ACC_EN (adds acc_Pad; operand B taken from
// the currently held sum_Pad when acc_Pad is high).
//   GCLK_Pad, rst_n_Pad      : clock, asynchronous active-low reset
//   in_valid_Pad, a_Pad,
//   b_Pad, cin_Pad           : operation request
//   acc_Pad                  : (KSA_ACC_EN only) accumulate into last result
//   flush_Pad                : drop every in-flight operation
//   out_valid_Pad            : one-cycle pulse per result
//   sum_Pad, cout_Pad,
//   ovf_Pad                  : result, held until the next out_valid_Pad
//   cnt_Pad                  : results emitted, wrapping
module ksa_pipe_adder
  import ksa_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter bit          PIPE_PREFIX = 1'b1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             GCLK_Pad,
  input  logic             rst_n_Pad,
  input  logic             in_valid_Pad,
  input  logic [WIDTH-1:0] a_Pad,
  input  logic [WIDTH-1:0] b_Pad,
  input  logic             cin_Pad,
`ifdef KSA_ACC_EN
  input  logic             acc_Pad,
`endif
  input  logic             flush_Pad,
  output logic             out_valid_Pad,
  output logic [WIDTH-1:0] sum_Pad,
  output logic             cout_Pad,
  output logic             ovf_Pad,
  output logic [CNT_W-1:0] cnt_Pad
);

  localparam int unsigned LEVELS = clog2(WIDTH);
  localparam int unsigned SIDE_W = WIDTH + 1;

  if (WIDTH < 2 || WIDTH > KSA_MAX_W || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("ksa_pipe_adder: WIDTH must be a power of two in 2..64");
  end

  // Operand B select.
  logic [WIDTH-1:0] b_op_c;
`ifdef KSA_ACC_EN
  assign b_op_c = acc_Pad ? sum_Pad : b_Pad;
`else
  assign b_op_c = b_Pad;
`endif

  // PG generation; carry-in is folded into bit 0's generate so the prefix
  // tree yields true carries without an extra level.
  logic [WIDTH-1:0] p0_c;
  logic [WIDTH-1:0] g0_c;
  assign p0_c = a_Pad ^ b_op_c;
  assign g0_c = (a_Pad & b_op_c) | WIDTH'(p0_c[0] & cin_Pad);

  logic             s0_valid;
  logic [WIDTH-1:0] s0_g;
  logic [WIDTH-1:0] s0_p;
  logic             s0_cin;

  // PG register.
  always_ff @(posedge GCLK_Pad or negedge rst_n_Pad) begin
    if (!rst_n_Pad) begin
      s0_valid <= 1'b0;
      s0_g     <= '0;
      s0_p     <= '0;
      s0_cin   <= 1'b0;
    end else begin
      s0_valid <= in_valid_Pad & ~flush_Pad;
      s0_g     <= g0_c;
      s0_p     <= p0_c;
      s0_cin   <= cin_Pad;
    end
  end

  // Prefix tree; the side payload carries bit propagates and carry-in to the sum stage.
  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    logic              prev_valid;
    logic [WIDTH-1:0]  prev_g;
    logic [WIDTH-1:0]  prev_p;
    logic [SIDE_W-1:0] prev_side;
    logic              next_valid;
    logic [WIDTH-1:0]  next_g;
    logic [WIDTH-1:0]  next_p;
    logic [SIDE_W-1:0] next_side;

    if (k == 0) begin : g_src_pg
      assign prev_valid = s0_valid;
      assign prev_g     = s0_g;
      assign prev_p     = s0_p;
      assign prev_side  = {s0_p, s0_cin};
    end else begin : g_src_lvl
      assign prev_valid = g_lvl[k-1].next_valid;
      assign prev_g     = g_lvl[k-1].next_g;
      assign prev_p     = g_lvl[k-1].next_p;
      assign prev_side  = g_lvl[k-1].next_side;
    end

    ksa_prefix_level #(
      .WIDTH  (WIDTH),
      .DIST   (32'd1 << k),
      .SIDE_W (SIDE_W),
      .REG    (PIPE_PREFIX)
    ) u_level (
      .clk        (GCLK_Pad),
      .rst_n      (rst_n_Pad),
      .flush      (flush_Pad),
      .prev_valid (prev_valid),
      .prev_g     (prev_g),
      .prev_p     (prev_p),
      .prev_side  (prev_side),
      .next_valid (next_valid),
      .next_g     (next_g),
      .next_p     (next_p),
      .next_side  (next_side)
    );
  end

  // Sum stage: fin_g[i] is the carry out of bit i.
  logic             fin_valid;
  logic [WIDTH-1:0] fin_g;
  logic [WIDTH-1:0] fin_p_bits;
  logic             fin_cin;
  logic [WIDTH-1:0] carry_c;
  logic [WIDTH-1:0] sum_c;
  logic             take_c;
  logic             unused_fin_p;

  assign fin_valid              = g_lvl[LEVELS-1].next_valid;
  assign fin_g                  = g_lvl[LEVELS-1].next_g;
  assign {fin_p_bits, fin_cin}  = g_lvl[LEVELS-1].next_side;
  assign unused_fin_p           = ^g_lvl[LEVELS-1].next_p;
  assign carry_c                = {fin_g[WIDTH-2:0], fin_cin};
  assign sum_c                  = fin_p_bits ^ carry_c;
  // A flush also kills the result that would otherwise emerge on this edge.
  assign take_c                 = fin_valid & ~flush_Pad;

  // Sum / output hold register and result counter.
  always_ff @(posedge GCLK_Pad or negedge rst_n_Pad) begin
    if (!rst_n_Pad) begin
      out_valid_Pad <= 1'b0;
      sum_Pad       <= '0;
      cout_Pad      <= 1'b0;
      ovf_Pad       <= 1'b0;
      cnt_Pad       <= '0;
    end else begin
      out_valid_Pad <= take_c;
      if (take_c) begin
        sum_Pad  <= sum_c;
        cout_Pad <= fin_g[WIDTH-1];
        ovf_Pad  <= fin_g[WIDTH-1] ^ fin_g[WIDTH-2];
        cnt_Pad  <= cnt_Pad + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ksa_pipe_adder.sv
// Scoreboard bench for ksa_pipe_adder: an 8-bit pipelined instance and a
// 4-bit unpipelined instance with a 4-bit counter share one stimulus stream.
module tb_ksa_pipe_adder;

  localparam int unsigned LAT8 = 5;  // 8-bit, register per prefix level
  localparam int unsigned LAT4 = 2;  // 4-bit, PG and sum registers only

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] a_in = '0;
  logic [7:0] b_in = '0;
  logic       cin = 1'b0;
  logic       flush = 1'b0;
  logic       acc = 1'b0;

  logic        u8_ov, u8_cout, u8_ovf;
  logic [7:0]  u8_sum;
  logic [15:0] u8_cnt;
  logic        u4_ov, u4_cout, u4_ovf;
  logic [3:0]  u4_sum;
  logic [3:0]  u4_cnt;

  always #5 clk = ~clk;

  ksa_pipe_adder #(.WIDTH(8), .PIPE_PREFIX(1'b1), .CNT_W(16)) u8 (
    .GCLK_Pad(clk), .rst_n_Pad(rst_n), .in_valid_Pad(in_valid),
    .a_Pad(a_in), .b_Pad(b_in), .cin_Pad(cin),
`ifdef KSA_ACC_EN
    .acc_Pad(acc),
`endif
    .flush_Pad(flush), .out_valid_Pad(u8_ov), .sum_Pad(u8_sum),
    .cout_Pad(u8_cout), .ovf_Pad(u8_ovf), .cnt_Pad(u8_cnt)
  );

  ksa_pipe_adder #(.WIDTH(4), .PIPE_PREFIX(1'b0), .CNT_W(4)) u4 (
    .GCLK_Pad(clk), .rst_n_Pad(rst_n), .in_valid_Pad(in_valid),
    .a_Pad(a_in[3:0]), .b_Pad(b_in[3:0]), .cin_Pad(cin),
`ifdef KSA_ACC_EN
    .acc_Pad(acc),
`endif
    .flush_Pad(flush), .out_valid_Pad(u4_ov), .sum_Pad(u4_sum),
    .cout_Pad(u4_cout), .ovf_Pad(u4_ovf), .cnt_Pad(u4_cnt)
  );

  typedef struct {
    int         id;
    longint     due;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  hold_sum[2];
  logic        hold_cout[2];
  logic        hold_ovf[2];
  logic [15:0] mcnt[2];
  longint      cyc = 0;
  int          tests = 0;
  int          fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain modular addition at the instance's width.
  function automatic exp_t model(input int id, input logic [7:0] a, input logic [7:0] b,
                                 input logic c, input longint edge_no);
    exp_t        e;
    int unsigned w, mask, aa, bb, full, sa, sb_, ss;
    w    = (id == 0) ? 8 : 4;
    mask = (32'd1 << w) - 1;
    aa   = 32'(a) & mask;
    bb   = 32'(b) & mask;
    full = aa + bb + 32'(c);
    sa   = (aa >> (w - 1)) & 1;
    sb_  = (bb >> (w - 1)) & 1;
    ss   = (full >> (w - 1)) & 1;
    e.id   = id;
    e.due  = edge_no + ((id == 0) ? LAT8 : LAT4) - 1;
    e.sum  = 8'(full & mask);
    e.cout = ((full >> w) & 1) != 0;
    e.ovf  = (sa == sb_) && (ss != sa);
    return e;
  endfunction

  function automatic logic [15:0] cmask(input int id);
    return (id == 0) ? 16'hFFFF : 16'h000F;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor step for one instance: pops the oldest due entry and checks outputs.
  task automatic mon(input int id, input logic ov, input logic [7:0] s, input logic co,
                     input logic of, input logic [15:0] cn);
    int   idx;
    logic avail;
    idx = -1;
    for (int i = 0; i < sb.size(); i++) if (idx < 0 && sb[i].id == id) idx = i;
    avail = (idx >= 0) && (sb[idx].due <= cyc);
    tests++;
    if (ov !== avail) begin
      fails++;
      $display("FAIL valid[u%0d]: got out_valid=%0b, expected %0b (cycle %0d)",
               (id == 0) ? 8 : 4, ov, avail, cyc);
    end
    if (avail) begin
      hold_sum[id]  = sb[idx].sum;
      hold_cout[id] = sb[idx].cout;
      hold_ovf[id]  = sb[idx].ovf;
      mcnt[id]      = (mcnt[id] + 16'd1) & cmask(id);
      sb.delete(idx);
    end
    tests++;
    if (s !== hold_sum[id] || co !== hold_cout[id] || of !== hold_ovf[id] || cn !== mcnt[id]) begin
      fails++;
      $display("FAIL data[u%0d]: got sum=%0h cout=%0b ovf=%0b cnt=%0d, expected sum=%0h cout=%0b ovf=%0b cnt=%0d (cycle %0d)",
               (id == 0) ? 8 : 4, s, co, of, cn, hold_sum[id], hold_cout[id], hold_ovf[id], mcnt[id], cyc);
    end
  endtask

  always @(negedge clk) begin
    mon(0, u8_ov, u8_sum, u8_cout, u8_ovf, u8_cnt);
    mon(1, u4_ov, 8'(u4_sum), u4_cout, u4_ovf, 16'(u4_cnt));
  end

  task automatic clear_model();
    sb.delete();
    for (int id = 0; id < 2; id++) begin
      hold_sum[id] = '0; hold_cout[id] = 1'b0; hold_ovf[id] = 1'b0; mcnt[id] = '0;
    end
  endtask

  // Drive one cycle of stimulus for the next rising edge and update the scoreboard.
  task automatic issue(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic c, input logic fl, input logic ac);
    longint t;
    @(negedge clk);
    #1;
    in_valid = v; a_in = a; b_in = b; cin = c; flush = fl; acc = ac;
    t = cyc + 1;
    if (fl) begin
      for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].due >= t) sb.delete(i);
    end else if (v) begin
      for (int id = 0; id < 2; id++)
        sb.push_back(model(id, a, ac ? hold_sum[id] : b, c, t));
    end
  endtask

  task automatic drain();
    @(negedge clk);
    #1;
    in_valid = 1'b0; flush = 1'b0; acc = 1'b0;
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      @(negedge clk);
      #2;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic do_reset(input int cycles, input bit check_now);
    @(negedge clk);
    #1;
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; acc = 1'b0;
    clear_model();
    #1;
    if (check_now) begin
      chk("rst_now_u8", {u8_ov, u8_sum, u8_cout, u8_ovf, u8_cnt}, 64'd0);
      chk("rst_now_u4", {u4_ov, u4_sum, u4_cout, u4_ovf, u4_cnt}, 64'd0);
    end
    repeat (cycles) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    clear_model();
    #2;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Directed carry / overflow corners.
    issue(1, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    issue(1, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
    issue(1, 8'hFA, 8'h08, 1'b1, 1'b0, 1'b0);
    issue(1, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
    issue(1, 8'h80, 8'h80, 1'b0, 1'b0, 1'b0);
    drain();

    // Reset with work in flight.
    issue(1, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0);
    issue(1, 8'h56, 8'h78, 1'b1, 1'b0, 1'b0);
    issue(1, 8'h9A, 8'hBC, 1'b0, 1'b0, 1'b0);
    do_reset(2, 1'b1);
    repeat (10) issue(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("cnt_after_rst", 64'(u8_cnt), 64'd0);

    // Back-to-back random ops and counter wrap on the 4-bit counter.
    repeat (10) issue(1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'b0);
    drain();
    chk("cnt_u8_10", 64'(u8_cnt), 64'd10);
    chk("cnt_u4_10", 64'(u4_cnt), 64'd10);
    repeat (8) issue(1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'b0);
    drain();
    chk("cnt_u8_18", 64'(u8_cnt), 64'd18);
    chk("cnt_u4_wrap", 64'(u4_cnt), 64'd2);

    // Flush on the third issue cycle, held through the fourth.
    issue(1, 8'h11, 8'h22, 1'b0, 1'b0, 1'b0);
    issue(1, 8'h33, 8'h44, 1'b0, 1'b0, 1'b0);
    issue(1, 8'h55, 8'h66, 1'b0, 1'b1, 1'b0);
    issue(1, 8'h77, 8'h88, 1'b1, 1'b1, 1'b0);
    drain();
    chk("cnt_u8_flush", 64'(u8_cnt), 64'd18);

`ifdef KSA_ACC_EN
    // Accumulate reads the held result, not an in-flight one.
    issue(1, 8'h08, 8'h08, 1'b0, 1'b0, 1'b0);
    drain();
    issue(1, 8'h05, 8'hAA, 1'b0, 1'b0, 1'b1);
    issue(1, 8'h01, 8'h55, 1'b0, 1'b0, 1'b1);
    drain();
    chk("acc_second", 64'(u8_sum), 64'h11);
`endif

    // Random traffic with gaps and occasional flushes.
    for (int n = 0; n < 300; n++)
      issue($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 1'($urandom),
            $urandom_range(0, 15) == 0, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
